hier_seq_node: RTL
==================

# hier_seq_node

Parametrised hierarchy node for the generated module tree. It replaces fixed fan-out containers with one configurable node that launches up to NUM_CHILDREN child blocks, in parallel or one after another. The node collects each child's completion, applies a per-launch timeout, and returns a single status record to its parent over a valid/ready handshake. Any level of the tree, from root to leaf-parent, can instantiate it.

## Interface
- NUM_CHILDREN, 5, number of child ports; 1..32
- TIMEOUT_W, 8, timer width; timeout limit = 2^TIMEOUT_W - 1 cycles
- MODE, 0, 0 = PARALLEL launch, 1 = SEQUENTIAL launch (lowest index first)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start_valid  in  1  parent requests a run
- start_ready  out  1  node can accept a request
- start_mask  in  NUM_CHILDREN  children to launch, sampled on accept
- child_start  out  NUM_CHILDREN  one-cycle launch pulse per child
- child_done  in  NUM_CHILDREN  completion pulse or level from each child
- done_valid  out  1  status record available
- done_ready  in  1  parent consumes status
- done_mask  out  NUM_CHILDREN  children that completed in this run
- done_timeout  out  1  run ended by timeout

## Operation
- States: IDLE, LAUNCH, WAIT, REPORT. Reset forces IDLE from any state and aborts any run in progress.
- Reset values: child_start=0, done_valid=0, done_mask=0, done_timeout=0, start_ready=0 while rst is high.
- IDLE: start_ready=1. On start_valid & start_ready:
  - latch start_mask into pending and clear done_seen.
  - If the mask is 0, go to REPORT with done_mask=0 and done_timeout=0.
  - Otherwise go to LAUNCH.
- LAUNCH lasts one cycle and clears the timer.
  - PARALLEL: child_start = pending.
  - SEQUENTIAL: child_start = onehot(lowest set bit of the not-yet-done pending bits).
- WAIT:
  - Each cycle, done_seen |= child_done & launched. Done from unlaunched or unmasked children is ignored.
  - The timer increments each cycle.
  - PARALLEL: when done_seen == pending, go to REPORT.
  - SEQUENTIAL: when the current child's done is seen, go to LAUNCH for the next pending child, or to REPORT if none remain.
- Timeout: if the timer reaches its limit in WAIT with the current wait unsatisfied, go to REPORT with done_timeout=1.
  - In SEQUENTIAL mode, the remaining children are not launched.
- A child_done seen in the same cycle the timer hits its limit counts as completion; no timeout is raised.
- REPORT:
  - done_valid=1; done_mask = done_seen; done_timeout holds.
  - All three stay stable until done_ready. On handshake, return to IDLE.
  - start_ready=0 throughout REPORT, so no new request overlaps an unconsumed status.

## Timing
- Request accepted at edge T. child_start is high in cycle T+1 (LAUNCH).
- The earliest child_done is sampled in cycle T+2; done_valid rises at T+3.
- SEQUENTIAL: each additional child adds at least 2 cycles (LAUNCH + WAIT).
- Timeout: done_valid rises 2^TIMEOUT_W cycles after LAUNCH at the latest. The timer restarts on every LAUNCH.
- start_ready is combinational from state, so back-to-back runs can be accepted the cycle after the done handshake.
- child_start is registered, glitch-free, and never high for more than one cycle.

## Structure
- Package hier_node_pkg holds:
  - state_e (IDLE, LAUNCH, WAIT, REPORT).
  - mode_e (PARALLEL, SEQUENTIAL).
  - The lowest-set-bit onehot function.
- Sub-module hier_node_timer: TIMEOUT_W-bit counter with clear, enable and expired outputs, on the same clk and rst.

## Test plan
- **Parallel, all children respond.** NUM_CHILDREN=5, mask 5'b11111, all children done at T+4. Expect child_start=5'b11111 at T+1, done_valid at T+5, done_mask=5'b11111, done_timeout=0.
- **Sequential ordering.** Mask 5'b10110, each child done 2 cycles after its start. Expect start pulses on bits 1, 2, 4 in order, each exactly one cycle wide, and done_mask=5'b10110.
- **Timeout.** TIMEOUT_W=4, mask 5'b00011, child 1 never responds. Expect done_timeout=1, done_mask=5'b00001, and done_valid within 16 cycles of LAUNCH. In SEQUENTIAL mode, child 1 starts after child 0 and the same status results.
- **Empty mask and backpressure.** Mask 0, then done_ready held low 10 cycles. Expect done_valid at T+1 with done_mask=0, outputs stable 10 cycles, start_ready=0 throughout.
- **Spurious done and reset mid-run.** child_done on an unmasked child is ignored. Assert rst during WAIT: the next cycle is IDLE with all outputs at reset values, and a new request completes normally.

Source files
------------

// File: rtl/hier_node_pkg.sv
// Shared types and helpers for the hierarchy sequencing node.
package hier_node_pkg;

  localparam int unsigned MAX_CHILDREN = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    REPORT = 2'd3
  } state_e;

  typedef enum logic {
    PARALLEL   = 1'b0,
    SEQUENTIAL = 1'b1
  } mode_e;

  // Isolate the lowest set bit as a one-hot vector (zero in, zero out).
  function automatic logic [MAX_CHILDREN-1:0] lowest_onehot(input logic [MAX_CHILDREN-1:0] v);
    return v & (~v + MAX_CHILDREN'(1));
  endfunction

endpackage

// File: rtl/hier_node_timer.sv
// Per-launch timeout counter: saturates at all-ones and flags expiry there.
module hier_node_timer #(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LIMIT = '1;

  logic [TIMEOUT_W-1:0] count;

  // Clear wins over enable so a relaunch always starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/hier_seq_node.sv
// Hierarchy node: launches masked children in parallel or in index order,
// gathers completions under a per-launch timeout, returns one status record.
module hier_seq_node #(
  parameter int unsigned NUM_CHILDREN = 5,
  parameter int unsigned TIMEOUT_W    = 8,
  parameter int unsigned MODE         = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [NUM_CHILDREN-1:0] start_mask,
  output logic [NUM_CHILDREN-1:0] child_start,
  input  logic [NUM_CHILDREN-1:0] child_done,
  output logic                    done_valid,
  input  logic                    done_ready,
  output logic [NUM_CHILDREN-1:0] done_mask,
  output logic                    done_timeout
);

  import hier_node_pkg::*;

  localparam int unsigned N        = NUM_CHILDREN;
  localparam mode_e       MODE_SEL = (MODE == 0) ? PARALLEL : SEQUENTIAL;

  state_e         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   seen_q, seen_d;
  logic [N-1:0]   launched_q, launched_d;
  logic [N-1:0]   current_q, current_d;
  logic           timeout_q, timeout_d;
  logic [N-1:0]   start_d;
  logic [N-1:0]   remaining;
  logic           timer_clear;
  logic           timer_en;
  logic           timer_expired;

  hier_node_timer #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  // Next-state, run bookkeeping and launch selection.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    seen_d      = seen_q;
    launched_d  = launched_q;
    current_d   = current_q;
    timeout_d   = timeout_q;
    start_d     = '0;
    remaining   = '0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          pending_d  = start_mask;
          seen_d     = '0;
          launched_d = '0;
          current_d  = '0;
          timeout_d  = 1'b0;
          state_d    = (start_mask == '0) ? REPORT : LAUNCH;
        end
      end
      LAUNCH: begin
        timer_en = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        timer_en = 1'b1;
        seen_d   = seen_q | (child_done & launched_q);
        if (MODE_SEL == SEQUENTIAL) begin
          if ((seen_d & current_q) != '0) begin
            remaining = pending_q & ~seen_d;
            state_d   = (remaining != '0) ? LAUNCH : REPORT;
          end else if (timer_expired) begin
            timeout_d = 1'b1;
            state_d   = REPORT;
          end
        end else begin
          if (seen_d == pending_q) begin
            state_d = REPORT;
          end else if (timer_expired) begin
            timeout_d = 1'b1;
            state_d   = REPORT;
          end
        end
      end
      REPORT: begin
        if (done_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Launch pulses are computed on entry to LAUNCH so they can be registered.
    if (state_d == LAUNCH) begin
      timer_clear = 1'b1;
      if (MODE_SEL == SEQUENTIAL) begin
        start_d   = N'(lowest_onehot(MAX_CHILDREN'(pending_d & ~seen_d)));
        current_d = start_d;
      end else begin
        start_d = pending_d;
      end
      launched_d = launched_d | start_d;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      seen_q       <= '0;
      launched_q   <= '0;
      current_q    <= '0;
      timeout_q    <= 1'b0;
      child_start  <= '0;
      done_valid   <= 1'b0;
      done_mask    <= '0;
      done_timeout <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      seen_q       <= seen_d;
      launched_q   <= launched_d;
      current_q    <= current_d;
      timeout_q    <= timeout_d;
      child_start  <= start_d;
      done_valid   <= (state_d == REPORT);
      done_mask    <= (state_d == REPORT) ? seen_d : '0;
      done_timeout <= (state_d == REPORT) && timeout_d;
    end
  end

  assign start_ready = (state_q == IDLE) && !rst;

endmodule
